puf_response_voter: RTL and testbench

Evaluation controller placed directly upstream of the arbiter PUF array, and it also consumes the array's output. It accepts a challenge over a valid/ready handshake and drives it, held stable, onto the PUF challenge lines. It then fires the PUF pulse N_EVAL times and synchronises and counts the raw response bits. Each bit is majority-voted, and the result is returned with a per-bit instability flag.

---
 rtl/puf_response_voter.sv | 153 +++++++++++++++
 tb/tb_puf_response_voter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_response_voter.sv
// Arbiter-PUF evaluation controller: holds a challenge on the PUF, fires N_EVAL pulses,
// majority-votes each synchronised response bit and flags bits whose votes disagreed.
module puf_response_voter #(
  parameter int unsigned C_LENGTH = 8,
  parameter int unsigned R_WIDTH  = 8,
  parameter int unsigned N_EVAL   = 7,
  parameter int unsigned SETTLE   = 4
) (
  input  logic                iclk,
  input  logic                ireset,
  input  logic                ichallenge_valid,
  input  logic [C_LENGTH-1:0] ichallenge,
  output logic                ochallenge_ready,
  output logic                opulse,
  output logic [C_LENGTH-1:0] opuf_challenge,
  input  logic [R_WIDTH-1:0]  ipuf_response,
  output logic [R_WIDTH-1:0]  oresponse,
  output logic [R_WIDTH-1:0]  ounstable,
  output logic                oresponse_valid,
  input  logic                iresponse_ready
);

  if ((N_EVAL % 2) != 1) begin : g_bad_n_eval
    $error("N_EVAL must be odd and at least 1");
  end
  if (SETTLE < 3) begin : g_bad_settle
    $error("SETTLE must be at least 3");
  end

  localparam int unsigned CntW = $clog2(N_EVAL + 1);
  localparam int unsigned EvW  = $clog2(N_EVAL + 1);
  localparam int unsigned PhW  = $clog2(SETTLE);

  localparam logic [CntW-1:0] CntHalf = CntW'(N_EVAL / 2);
  localparam logic [CntW-1:0] CntFull = CntW'(N_EVAL);
  localparam logic [EvW-1:0]  EvLast  = EvW'(N_EVAL - 1);
  localparam logic [PhW-1:0]  PhLast  = PhW'(SETTLE - 1);

  typedef enum logic [2:0] {StIdle, StLow, StHigh, StVote, StDone} state_e;

  state_e                         state_q, state_d;
  logic [PhW-1:0]                 phase_q, phase_d;
  logic [EvW-1:0]                 eval_q, eval_d;
  logic [R_WIDTH-1:0][CntW-1:0]   cnt_q, cnt_d;
  logic [R_WIDTH-1:0]             sync1_q, sync2_q;
  logic                           pulse_q, pulse_d;
  logic [C_LENGTH-1:0]            chal_q, chal_d;
  logic [R_WIDTH-1:0]             resp_q, resp_d;
  logic [R_WIDTH-1:0]             unst_q, unst_d;
  logic                           valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    eval_d  = eval_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    chal_d  = chal_q;
    resp_d  = resp_q;
    unst_d  = unst_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        // ochallenge_ready is 1 here, so valid alone completes the handshake
        if (ichallenge_valid) begin
          chal_d  = ichallenge;
          cnt_d   = '0;
          eval_d  = '0;
          phase_d = '0;
          state_d = StLow;
        end
      end
      StLow: begin
        if (phase_q == PhLast) begin
          phase_d = '0;
          pulse_d = 1'b1;
          state_d = StHigh;
        end else begin
          phase_d = phase_q + PhW'(1);
        end
      end
      StHigh: begin
        pulse_d = 1'b1;
        if (phase_q == PhLast) begin
          phase_d = '0;
          pulse_d = 1'b0;
          for (int unsigned i = 0; i < R_WIDTH; i++) begin
            cnt_d[i] = cnt_q[i] + CntW'(sync2_q[i]);
          end
          if (eval_q == EvLast) begin
            state_d = StVote;
          end else begin
            eval_d  = eval_q + EvW'(1);
            state_d = StLow;
          end
        end else begin
          phase_d = phase_q + PhW'(1);
        end
      end
      StVote: begin
        for (int unsigned i = 0; i < R_WIDTH; i++) begin
          resp_d[i] = (cnt_q[i] > CntHalf);
          unst_d[i] = (cnt_q[i] != '0) && (cnt_q[i] != CntFull);
        end
        valid_d = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        if (iresponse_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_q <= StIdle;
      phase_q <= '0;
      eval_q  <= '0;
      cnt_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      pulse_q <= 1'b0;
      chal_q  <= '0;
      resp_q  <= '0;
      unst_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      eval_q  <= eval_d;
      cnt_q   <= cnt_d;
      sync1_q <= ipuf_response;
      sync2_q <= sync1_q;
      pulse_q <= pulse_d;
      chal_q  <= chal_d;
      resp_q  <= resp_d;
      unst_q  <= unst_d;
      valid_q <= valid_d;
    end
  end

  assign ochallenge_ready = (state_q == StIdle);
  assign opulse           = pulse_q;
  assign opuf_challenge   = chal_q;
  assign oresponse        = resp_q;
  assign ounstable        = unst_q;
  assign oresponse_valid  = valid_q;

endmodule

// File: tb/tb_puf_response_voter.sv
// Directed bench for puf_response_voter: behavioural PUF model, expected results queued by the
// stimulus and checked by an independent negedge monitor.
module tb_puf_response_voter;

  localparam int Latency = 58;  // 2*SETTLE*N_EVAL + 2 with defaults
  localparam int NEval   = 7;
  localparam int Settle  = 4;

  logic       iclk = 1'b0;
  logic       ireset = 1'b0;
  logic       ichallenge_valid = 1'b0;
  logic [7:0] ichallenge = 8'h00;
  logic       ochallenge_ready;
  logic       opulse;
  logic [7:0] opuf_challenge;
  logic [7:0] ipuf_response = 8'h00;
  logic [7:0] oresponse;
  logic [7:0] ounstable;
  logic       oresponse_valid;
  logic       iresponse_ready = 1'b1;

  puf_response_voter dut (
    .iclk             (iclk),
    .ireset           (ireset),
    .ichallenge_valid (ichallenge_valid),
    .ichallenge       (ichallenge),
    .ochallenge_ready (ochallenge_ready),
    .opulse           (opulse),
    .opuf_challenge   (opuf_challenge),
    .ipuf_response    (ipuf_response),
    .oresponse        (oresponse),
    .ounstable        (ounstable),
    .oresponse_valid  (oresponse_valid),
    .iresponse_ready  (iresponse_ready)
  );

  always #5 iclk = ~iclk;

  int cyc = 0;
  always @(posedge iclk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural arbiter PUF: new response shortly after each pulse rising edge
  logic [7:0] pat [NEval];
  int pidx = 0;
  always @(posedge opulse) begin
    #2 ipuf_response = pat[pidx % NEval];
    pidx = pidx + 1;
  end

  task automatic set_stable(input logic [7:0] v);
    for (int i = 0; i < NEval; i++) pat[i] = v;
    pidx = 0;
  endtask

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] u;
  } exp_t;
  exp_t exp_q[$];
  int   acc_q[$];
  int   acc_count = 0;
  int   rises = 0;

  // Monitor: accept timestamps, pulse shape, and result comparison against the queue
  initial begin
    logic prev_p, prev_v;
    int   high_run;
    exp_t e;
    int   a;
    prev_p = 1'b0;
    prev_v = 1'b0;
    high_run = 0;
    forever begin
      @(negedge iclk);
      if (ireset) begin
        prev_p = 1'b0;
        prev_v = 1'b0;
        high_run = 0;
      end else begin
        if (ichallenge_valid && ochallenge_ready) begin
          acc_q.push_back(cyc);
          acc_count++;
          rises = 0;
        end
        if (opulse && !prev_p) begin
          rises++;
          high_run = 1;
        end else if (opulse) begin
          high_run++;
        end else if (prev_p) begin
          check("pulse_width", high_run, Settle);
        end
        if (oresponse_valid && !prev_v) begin
          check("sb_pending", (exp_q.size() > 0 && acc_q.size() > 0), 1);
          if (exp_q.size() > 0 && acc_q.size() > 0) begin
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            check("oresponse", oresponse, e.r);
            check("ounstable", ounstable, e.u);
            check("valid_latency", cyc - a, Latency);
            check("pulse_count", rises, NEval);
            check("pulse_low_done", opulse, 0);
          end
        end
        prev_p = opulse;
        prev_v = oresponse_valid;
      end
    end
  end

  task automatic send(input logic [7:0] ch, input logic [7:0] er, input logic [7:0] eu);
    int n;
    exp_q.push_back('{r: er, u: eu});
    @(posedge iclk);
    #1;
    ichallenge = ch;
    ichallenge_valid = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge iclk);
      if (ochallenge_ready) break;
    end
    check("accept_ready", ochallenge_ready, 1);
    @(posedge iclk);
    #1 ichallenge_valid = 1'b0;
    @(negedge iclk);
    check("chal_captured", opuf_challenge, ch);
  endtask

  task automatic wait_valid();
    for (int n = 0; n < 200; n++) begin
      @(negedge iclk);
      if (oresponse_valid) break;
    end
    check("valid_seen", oresponse_valid, 1);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 200; n++) begin
      @(negedge iclk);
      if (ochallenge_ready) break;
    end
    check("idle_seen", ochallenge_ready, 1);
  endtask

  task automatic check_reset_outputs();
    check("rst_opulse", opulse, 0);
    check("rst_challenge", opuf_challenge, 0);
    check("rst_response", oresponse, 0);
    check("rst_unstable", ounstable, 0);
    check("rst_valid", oresponse_valid, 0);
    check("rst_ready", ochallenge_ready, 1);
  endtask

  initial begin
    int a0;
    int n;
    // Reset asserted between clock edges
    #7 ireset = 1'b1;
    #1 check_reset_outputs();
    @(posedge iclk);
    #1 ireset = 1'b0;
    repeat (3) @(negedge iclk);
    check_reset_outputs();

    // Stable response
    set_stable(8'hA5);
    send(8'h3C, 8'hA5, 8'h00);
    wait_valid();
    wait_idle();

    // Noisy: bit0 set on 4 of 7 pulses, bit7 on 3 of 7
    pat[0] = 8'h01; pat[1] = 8'h01; pat[2] = 8'h01; pat[3] = 8'h01;
    pat[4] = 8'h80; pat[5] = 8'h80; pat[6] = 8'h80;
    pidx = 0;
    send(8'h5C, 8'h01, 8'h81);
    wait_valid();
    wait_idle();

    // Backpressure with a competing challenge
    @(posedge iclk);
    #1 iresponse_ready = 1'b0;
    set_stable(8'h77);
    send(8'h11, 8'h77, 8'h00);
    wait_valid();
    @(posedge iclk);
    #1;
    ichallenge = 8'hFF;
    ichallenge_valid = 1'b1;
    repeat (10) begin
      @(negedge iclk);
      check("bp_valid", oresponse_valid, 1);
      check("bp_response", oresponse, 8'h77);
      check("bp_ready", ochallenge_ready, 0);
      check("bp_challenge", opuf_challenge, 8'h11);
    end
    set_stable(8'hC3);
    exp_q.push_back('{r: 8'hC3, u: 8'h00});
    @(posedge iclk);
    #1 iresponse_ready = 1'b1;
    @(negedge iclk);
    check("hs_valid_d", oresponse_valid, 1);
    @(negedge iclk);
    check("hs_ready_d1", ochallenge_ready, 1);
    check("hs_valid_d1", oresponse_valid, 0);
    @(posedge iclk);
    #1 ichallenge_valid = 1'b0;
    @(negedge iclk);
    check("ff_captured", opuf_challenge, 8'hFF);
    wait_valid();
    wait_idle();

    // Reset during HIGH of evaluation 3
    set_stable(8'h33);
    send(8'h42, 8'h33, 8'h00);
    for (n = 0; n < 300; n++) begin
      @(negedge iclk);
      if (rises == 4 && opulse) break;
    end
    check("eval3_high", opulse, 1);
    #2 ireset = 1'b1;
    #1;
    check("mid_rst_pulse", opulse, 0);
    check("mid_rst_valid", oresponse_valid, 0);
    check("mid_rst_ready", ochallenge_ready, 1);
    repeat (2) @(negedge iclk);
    @(posedge iclk);
    #1 ireset = 1'b0;
    exp_q.delete();
    acc_q.delete();
    set_stable(8'h5A);
    send(8'h99, 8'h5A, 8'h00);
    wait_valid();
    wait_idle();

    // Toggle challenge inputs throughout a run
    set_stable(8'h6E);
    a0 = acc_count;
    send(8'h24, 8'h6E, 8'h00);
    for (n = 0; n < 200; n++) begin
      @(posedge iclk);
      #1;
      ichallenge_valid = ~ichallenge_valid;
      ichallenge = ~ichallenge;
      @(negedge iclk);
      check("hold_challenge", opuf_challenge, 8'h24);
      if (oresponse_valid) break;
    end
    check("toggle_valid_seen", oresponse_valid, 1);
    @(posedge iclk);
    #1 ichallenge_valid = 1'b0;
    wait_idle();
    check("single_accept", acc_count - a0, 1);

    repeat (3) @(negedge iclk);
    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
